// File: rtl/registered_fpa_pkg.sv
// Shared definitions for the registered binary32 adder: format constants,
// the unpacked field struct, and the small helper functions used by the core.
// Optional feature macro: ROUND_NEAREST_EN (round-to-nearest-even instead of truncation).
package fpa_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

`ifdef ROUND_NEAREST_EN
    localparam logic RNE_EN = 1'b1;
`else
    localparam logic RNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_fields_t;

    // Split a binary32 word into its sign/exponent/fraction fields.
    function automatic fp_fields_t unpack_fp(input logic [31:0] w);
        fp_fields_t f;
        f.sign = w[31];
        f.exp  = w[30:23];
        f.frac = w[22:0];
        return f;
    endfunction

    // Leading-zero count of a 27-bit aligned significand (returns 27 for zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 5'd1;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/registered_fpa_if.sv
// Operand/result bundle for the registered adder. The master drives the
// operands and stage enable; the slave (the adder) returns sum and overflow.
interface registered_fpa_if;
    logic        enable;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic        overflow;

    modport master (output enable, output in1, output in2, input out, input overflow);
    modport slave  (input enable, input in1, input in2, output out, output overflow);
endinterface

// File: rtl/registered_fpa_core.sv
// Purely combinational binary32 adder: special-case handling, alignment with
// guard/round/sticky, add/subtract, normalisation and rounding (truncation by
// default, round-to-nearest-even when ROUND_NEAREST_EN is defined).
module fp_add_core
    import fpa_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        ovf_o
);

    fp_fields_t         fa_s, fb_s, big_s, small_s;
    logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic [7:0]         diff_s;
    logic [23:0]        mant_big_s, mant_small_s;
    logic [49:0]        wide_s;
    logic [26:0]        aligned_s;
    logic [27:0]        raw_s;
    logic [4:0]         lz_s;
    logic [26:0]        norm_s;
    logic signed [9:0]  exp_n_s, exp_r_s;
    logic               round_up_s;
    logic [24:0]        mant_r_s;
    logic [23:0]        mant_f_s;
    logic [31:0]        norm_res_s;
    logic               norm_ovf_s;

    // Normal-path datapath: order by magnitude, align, add/sub, normalise, round, range-check.
    always_comb begin
        fa_s = unpack_fp(a_i);
        fb_s = unpack_fp(b_i);

        // Comparing {exp,frac} orders magnitudes, so the subtraction below never goes negative.
        if ({fa_s.exp, fa_s.frac} >= {fb_s.exp, fb_s.frac}) begin
            big_s   = fa_s;
            small_s = fb_s;
        end else begin
            big_s   = fb_s;
            small_s = fa_s;
        end

        diff_s       = big_s.exp - small_s.exp;
        mant_big_s   = {1'b1, big_s.frac};
        mant_small_s = {1'b1, small_s.frac};

        // 24 significand bits + guard + round + sticky; huge shifts collapse into sticky.
        if (diff_s >= 8'd26) begin
            wide_s    = 50'd0;
            aligned_s = 27'd1;
        end else begin
            wide_s    = {mant_small_s, 26'd0} >> diff_s;
            aligned_s = {wide_s[49:24], |wide_s[23:0]};
        end

        if (big_s.sign ^ small_s.sign) begin
            raw_s = {1'b0, mant_big_s, 3'b000} - {1'b0, aligned_s};
        end else begin
            raw_s = {1'b0, mant_big_s, 3'b000} + {1'b0, aligned_s};
        end

        lz_s = lzc27(raw_s[26:0]);
        if (raw_s[27]) begin
            norm_s  = {raw_s[27:2], raw_s[1] | raw_s[0]};
            exp_n_s = $signed({2'b00, big_s.exp}) + 10'sd1;
        end else begin
            norm_s  = raw_s[26:0] << lz_s;
            exp_n_s = $signed({2'b00, big_s.exp}) - $signed({5'd0, lz_s});
        end

        round_up_s = RNE_EN & norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_r_s   = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
        if (mant_r_s[24]) begin
            mant_f_s = mant_r_s[24:1];
            exp_r_s  = exp_n_s + 10'sd1;
        end else begin
            mant_f_s = mant_r_s[23:0];
            exp_r_s  = exp_n_s;
        end

        norm_ovf_s = 1'b0;
        if (raw_s == 28'd0) begin
            norm_res_s = 32'h00000000;
        end else if (exp_r_s >= 10'sd255) begin
            norm_res_s = {big_s.sign, EXP_MAX, 23'd0};
            norm_ovf_s = 1'b1;
        end else if (exp_r_s <= 10'sd0) begin
            norm_res_s = {big_s.sign, 31'd0};
        end else begin
            norm_res_s = {big_s.sign, exp_r_s[7:0], mant_f_s[22:0]};
        end
    end

    // Special-operand classification and final result selection in priority order.
    always_comb begin
        a_nan_s  = (fa_s.exp == EXP_MAX) && (fa_s.frac != 23'd0);
        b_nan_s  = (fb_s.exp == EXP_MAX) && (fb_s.frac != 23'd0);
        a_inf_s  = (fa_s.exp == EXP_MAX) && (fa_s.frac == 23'd0);
        b_inf_s  = (fb_s.exp == EXP_MAX) && (fb_s.frac == 23'd0);
        a_zero_s = (fa_s.exp == 8'd0);
        b_zero_s = (fb_s.exp == 8'd0);

        sum_o = norm_res_s;
        ovf_o = norm_ovf_s;
        if (a_nan_s || b_nan_s) begin
            sum_o = QNAN;
            ovf_o = 1'b0;
        end else if (a_inf_s && b_inf_s && (fa_s.sign != fb_s.sign)) begin
            sum_o = QNAN;
            ovf_o = 1'b0;
        end else if (a_inf_s) begin
            sum_o = fa_s.sign ? NEG_INF : POS_INF;
            ovf_o = 1'b1;
        end else if (b_inf_s) begin
            sum_o = fb_s.sign ? NEG_INF : POS_INF;
            ovf_o = 1'b1;
        end else if (a_zero_s && b_zero_s) begin
            // Denormals count as zeros; only -0 + -0 keeps the negative sign.
            sum_o = {fa_s.sign & fb_s.sign, 31'd0};
            ovf_o = 1'b0;
        end else if (a_zero_s) begin
            sum_o = b_i;
            ovf_o = 1'b0;
        end else if (b_zero_s) begin
            sum_o = a_i;
            ovf_o = 1'b0;
        end else begin
            sum_o = norm_res_s;
            ovf_o = norm_ovf_s;
        end
    end

endmodule

// File: rtl/registered_fpa.sv
// Two-stage registered binary32 adder: operand registers feed one combinational
// fp_add_core whose result and overflow flag are captured in output registers.
// Both stages advance only on enabled edges. Optional macro: ROUND_NEAREST_EN.
module registered_fpa
    import fpa_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    registered_fpa_if.slave bus
);

    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] out_q, out_d;
    logic        ovf_q, ovf_d;
    logic [31:0] core_sum_s;
    logic        core_ovf_s;

    fp_add_core u_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (core_sum_s),
        .ovf_o (core_ovf_s)
    );

    // Next-state: capture new operands and the previous operands' sum only when enabled.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        ovf_d = ovf_q;
        if (bus.enable) begin
            a_d   = bus.in1;
            b_d   = bus.in2;
            out_d = core_sum_s;
            ovf_d = core_ovf_s;
        end else begin
            a_d   = a_q;
            b_d   = b_q;
            out_d = out_q;
            ovf_d = ovf_q;
        end
    end

    // Pipeline registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            out_q <= 32'd0;
            ovf_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_registered_fpa.sv
// Directed bench for registered_fpa: hand-computed binary32 sums, enable hold,
// and asynchronous reset behaviour.
module tb_registered_fpa;

    logic clk;
    logic reset;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;

    registered_fpa_if bus ();

    registered_fpa dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    // Present operands for two enabled edges, then check the registered result.
    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_out, input logic exp_ovf);
        @(negedge clk);
        bus.in1    = a;
        bus.in2    = b;
        bus.enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.in1    = 32'h00000000;
        bus.in2    = 32'h00000000;
        #2;
        check("reset.out", bus.out, 32'h00000000);
        check("reset.ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_vec("inf_plus_one",   32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b1);
        run_vec("ninf_plus_neg1", 32'hFF800000, 32'hBF800000, 32'hFF800000, 1'b1);
        run_vec("p15_m55",        32'h3FC00000, 32'hC0B00000, 32'hC0800000, 1'b0);
        run_vec("p125_p25",       32'h3FA00000, 32'h40200000, 32'h40700000, 1'b0);
        run_vec("m125_m25",       32'hBFA00000, 32'hC0200000, 32'hC0700000, 1'b0);
        run_vec("zero_plus_x",    32'h00000000, 32'h3F99999A, 32'h3F99999A, 1'b0);
        run_vec("max_plus_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
        run_vec("inf_minus_inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
        run_vec("nan_plus_one",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        run_vec("nzero_nzero",    32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
        run_vec("denorm_nzero",   32'h00000001, 32'h80000000, 32'h00000000, 1'b0);
        run_vec("cancel",         32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
        run_vec("far_shift",      32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0);
        run_vec("underflow",      32'h00800000, 32'h80800001, 32'h80000000, 1'b0);
`ifdef ROUND_NEAREST_EN
        run_vec("round_bits",     32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0);
`else
        run_vec("round_bits",     32'h3F800000, 32'h33C00000, 32'h3F800000, 1'b0);
`endif

        // Enable hold: operand register and output must both freeze while enable=0.
        run_vec("pre_hold",       32'h3FA00000, 32'h40200000, 32'h40700000, 1'b0);
        @(negedge clk);
        bus.in1 = 32'h3FC00000;
        bus.in2 = 32'hC0B00000;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b0;
        bus.in1    = 32'h7F800000;
        bus.in2    = 32'h3F800000;
        repeat (3) @(posedge clk);
        #1;
        check("hold.out", bus.out, 32'h40700000);
        check("hold.ovf", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        check("resume.out", bus.out, 32'hC0800000);
        @(posedge clk);
        #1;
        check("resume2.out", bus.out, 32'h7F800000);
        check("resume2.ovf", {31'd0, bus.overflow}, 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.out", bus.out, 32'h00000000);
        check("async_rst.ovf", {31'd0, bus.overflow}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held.out", bus.out, 32'h00000000);
        @(negedge clk);
        reset = 1'b1;
        run_vec("after_reset",    32'hBFA00000, 32'hC0200000, 32'hC0700000, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
